// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the requesters / UART transmitter and the arbiter.
// The master side is the bus logic plus transmitter; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ack;
  logic [NUM_REQ-1:0]            grant;
  logic                          frame_abort;
  logic                          busy;
  logic                          tx_start;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_done;

  modport master (
    output req, req_data, req_last, tx_done,
    input  req_ack, grant, frame_abort, busy, tx_start, tx_data
  );

  modport slave (
    input  req, req_data, req_last, tx_done,
    output req_ack, grant, frame_abort, busy, tx_start, tx_data
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ requesters.
// One requester owns the link per frame; frames end on last, on MAX_FRAME bytes,
// or when the owner drops req. Every frame is followed by GAP_CLOCKS idle clocks.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_FRAME  = 16,
  parameter int GAP_CLOCKS = 16
) (
  input  logic             clk,
  input  logic             rstn,
  uart_tx_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_FRAME + 1);
  localparam int GAP_W = (GAP_CLOCKS > 1) ? $clog2(GAP_CLOCKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    GAP
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  last_q, last_d;
  logic                  tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0]    req_ack_q, req_ack_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  frame_abort_q, frame_abort_d;

  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      cand;

  // Find the first active request at or above the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic for the grant / send / gap sequence.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    last_d        = last_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    req_ack_d     = '0;
    frame_abort_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          ptr_d            = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
          cnt_d            = '0;
          state_d          = SEND;
        end
      end

      SEND: begin
        tx_start_d         = 1'b1;
        req_ack_d[owner_q] = 1'b1;
        tx_data_d          = bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
        last_d             = bus.req_last[owner_q];
        cnt_d              = cnt_q + CNT_W'(1);
        state_d            = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (bus.tx_done) begin
          if (last_q || (cnt_q == CNT_W'(MAX_FRAME))) begin
            grant_d = '0;
            gap_d   = '0;
            state_d = GAP;
          end else if (bus.req[owner_q]) begin
            state_d = SEND;
          end else begin
            frame_abort_d = 1'b1;
            grant_d       = '0;
            gap_d         = '0;
            state_d       = GAP;
          end
        end
      end

      GAP: begin
        if (gap_q == GAP_W'(GAP_CLOCKS - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Register all state and outputs; reset drops the link immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      grant_q       <= '0;
      cnt_q         <= '0;
      gap_q         <= '0;
      last_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      req_ack_q     <= '0;
      tx_data_q     <= '0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      last_q        <= last_d;
      tx_start_q    <= tx_start_d;
      req_ack_q     <= req_ack_d;
      tx_data_q     <= tx_data_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.req_ack     = req_ack_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.frame_abort = frame_abort_q;
  assign bus.busy        = (state_q != IDLE);

endmodule
